seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter (legal range 1..16).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input_bit is consumed this cycle.
REQ-007 SHALL have port input_bit, input, 1 bit: serial data bit.
REQ-008 SHALL have port cfg_load, input, 1 bit: capture the configuration and flush the history.
REQ-009 SHALL have port cfg_pattern, input, PAT_W bits: target pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-010 SHALL have port cfg_len, input, $clog2(PAT_W+1) bits: active pattern length.
REQ-011 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port clear, input, 1 bit: zero match_count and overflow.
REQ-013 SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-014 SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set by a match while the count is saturated.
REQ-016 SHALL have port cfg_err, output, 1 bit: the loaded cfg_len is 0 or greater than PAT_W.

Function
REQ-017 SHALL hold internal registers pat_q, len_q and ovl_q, written only on a cfg_load cycle.
REQ-018 SHALL keep a history shift register hist of PAT_W bits and a fill counter fill, which saturates at PAT_W.
REQ-019 SHALL, on a cycle with in_valid=1 and cfg_load=0, update hist <= {hist[PAT_W-2:0], input_bit} and increment fill.
REQ-020 SHALL ignore input_bit when in_valid=0: hist, fill and detected hold or clear per REQ-023.
REQ-021 SHALL define a match on a consuming cycle as all of the following: the post-update fill >= len_q; the post-update hist[len_q-1:0] == pat_q[len_q-1:0]; cfg_err = 0.
REQ-022 SHALL, on a match, assert detected on the clock edge that consumes the final pattern bit, so detected is visible for the following cycle (latency 1).
REQ-023 SHALL hold detected high for exactly one cycle and drive it 0 otherwise, including during in_valid gaps.
REQ-024 SHALL, on a match with ovl_q=1, retain hist and fill so that suffix bits can start the next match.
REQ-025 SHALL, on a match with ovl_q=0, set fill to 0 so that the next match needs len_q fresh bits.
REQ-026 SHALL, on a match, increment match_count if it is below 2^CNT_W-1; otherwise hold it and set overflow.
REQ-027 SHALL, on cfg_load=1, capture the configuration, clear hist and fill, and discard that cycle's input_bit; cfg_load has priority over in_valid.
REQ-028 SHALL, on cfg_load=1, set cfg_err to (cfg_len==0 || cfg_len>PAT_W); while cfg_err=1, no match occurs.
REQ-029 SHALL, on clear=1, zero match_count and overflow; a match in the same cycle still pulses detected but is not counted, since clear wins.
REQ-030 SHALL NOT have clear affect hist, fill or the configuration.
REQ-031 SHALL handle cfg_load and clear asserted together: both take effect.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force hist=0, fill=0, detected=0, match_count=0, overflow=0 and cfg_err=0.
REQ-033 SHALL, while reset_n=0, asynchronously force pat_q=0, len_q=PAT_W and ovl_q=1.
REQ-034 SHALL, on reset mid-stream, discard partial matches; after release, detection restarts from an empty history.

Verification
REQ-035 SHALL cover overlap: PAT_W=8, load 1011 with len=4, ovl=1; stream 1,0,1,1,0,1,1 -> detected pulses after bits 4 and 7; match_count=2.
REQ-036 SHALL cover non-overlap: same setup with ovl=0, same stream -> one pulse after bit 4; match_count=1.
REQ-037 SHALL cover valid gaps: len=3, pattern 101; stream 1,(gap x3),0,1 -> one pulse after the final 1; detected=0 during the gaps.
REQ-038 SHALL cover saturation: CNT_W=2; 5 matches -> match_count=3, overflow=1; then clear -> both 0.
REQ-039 SHALL cover configuration edge cases: cfg_len=0 -> cfg_err=1 and no pulse on any stream; a cfg_load with in_valid=1 in the same cycle drops that bit.
REQ-040 SHALL cover reset mid-stream: after bits 1,0,1 of 1011, assert reset_n=0 then release; a following 1 -> no pulse; count=0 and len_q=PAT_W.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// detected pulses one cycle after the consuming edge of the final pattern bit.
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             input_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             clear,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_det;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_err;

  logic             w_consume;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_fill_nxt;
  logic [PAT_W-1:0] w_mask;
  logic [PAT_W-1:0] w_diff;
  logic             w_match;

  assign w_consume  = in_valid & ~cfg_load;
  assign w_hist_nxt = {r_hist[PAT_W-2:0], input_bit};
  assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

  // Only the low len_q bits of the history take part in the compare.
  for (genvar i = 0; i < PAT_W; i++) begin : g_cmp
    assign w_mask[i] = (LEN_W'(i) < r_len);
    assign w_diff[i] = w_mask[i] & (w_hist_nxt[i] ^ r_pat[i]);
  end

  assign w_match = w_consume && !r_err && (w_fill_nxt >= r_len) && (w_diff == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= '0;
      r_len  <= FILL_MAX;
      r_ovl  <= 1'b1;
      r_err  <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= cfg_len;
      r_ovl  <= cfg_overlap;
      r_err  <= (cfg_len == '0) || (cfg_len > FILL_MAX);
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_consume) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
      r_fill <= (w_match && !r_ovl) ? '0 : w_fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_det <= 1'b0;
    else          r_det <= w_match;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_match) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      else                  r_ovf <= 1'b1;
    end
  end

  assign detected    = r_det;
  assign match_count = r_cnt;
  assign overflow    = r_ovf;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a bit-list reference model queues the
// expected outputs per edge, a negedge monitor pops and compares them.
module tb_seq_detect_param;
  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, input_bit, cfg_load, cfg_overlap, clear;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             detected, overflow, cfg_err;
  logic [CNT_W-1:0] match_count;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .input_bit(input_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clear(clear), .detected(detected),
    .match_count(match_count), .overflow(overflow), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       det;
    int         cnt;
    logic       ovf;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the received bits since the last flush, plus the count of
  // bits that may still belong to a new match.
  logic       m_hist[$];
  int         m_fresh;
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl, m_err, m_ovf;
  int         m_cnt;
  int         cnt_max = (1 << CNT_W) - 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_fresh = 0; m_pat = '0; m_len = PAT_W; m_ovl = 1'b1; m_err = 1'b0;
    m_cnt = 0; m_ovf = 1'b0;
  endtask

  function automatic exp_t model_edge();
    exp_t e;
    logic hit;
    hit = 1'b0;
    if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_err = (m_len == 0) || (m_len > PAT_W);
      m_hist.delete(); m_fresh = 0;
    end else if (in_valid) begin
      m_hist.push_back(input_bit);
      if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
      m_fresh++;
      if (!m_err && m_fresh >= m_len) begin
        hit = 1'b1;
        // pattern bit k is the k-th most recent received bit
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_fresh = 0;
    end
    if (clear) begin
      m_cnt = 0; m_ovf = 1'b0;
    end else if (hit) begin
      if (m_cnt < cnt_max) m_cnt++;
      else m_ovf = 1'b1;
    end
    e.det = hit; e.cnt = m_cnt; e.ovf = m_ovf; e.err = m_err;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("detected",    int'(detected),    int'(e.det));
      chk("match_count", int'(match_count), e.cnt);
      chk("overflow",    int'(overflow),    int'(e.ovf));
      chk("cfg_err",     int'(cfg_err),     int'(e.err));
    end
  end

  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic clr);
    in_valid = v; input_bit = b; cfg_load = ld; cfg_pattern = p;
    cfg_len = l; cfg_overlap = o; clear = clr;
    @(posedge clk);
    exp_q.push_back(model_edge());
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                      input logic o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b1);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; cfg_load = 1'b0; clear = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_detected", int'(detected), 0);
    chk("rst_count",    int'(match_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_cfg_err",  int'(cfg_err), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 0; input_bit = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; clear = 0;
    model_reset();
    #12;
    chk("init_detected", int'(detected), 0);
    chk("init_count",    int'(match_count), 0);
    chk("init_overflow", int'(overflow), 0);
    chk("init_cfg_err",  int'(cfg_err), 0);
    reset_n = 1'b1;

    // overlap: 1011, stream 1011011 -> two pulses
    load(8'b1011, 4'd4, 1'b1);
    stream(32'b1011011, 7);
    idle(2);
    // non-overlap: same stream -> one pulse
    load(8'b1011, 4'd4, 1'b0);
    stream(32'b1011011, 7);
    idle(2);
    // valid gaps: 101 with three idle cycles after the first bit
    load(8'b101, 4'd3, 1'b1);
    bit_in(1'b1); idle(3); bit_in(1'b0); bit_in(1'b1);
    idle(2);
    // saturation: 5 matches of "11" with len 2 non-overlap, then clear
    load(8'b11, 4'd2, 1'b0);
    stream(32'h3FF, 10);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);
    // zero length and oversized length are config errors with no pulses
    load(8'b1, 4'd0, 1'b1);
    stream(32'hA5F0_0FFF, 32);
    load(8'hFF, 4'd9, 1'b1);
    stream(32'hFFFF, 16);
    // cfg_load with in_valid drops the bit: 1 dropped, then 01 must not match 101
    step(1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b1, 1'b0);
    bit_in(1'b0); bit_in(1'b1);
    bit_in(1'b0); bit_in(1'b1);
    idle(1);
    // reset mid-stream after 1,0,1 of 1011, then default config (8 zeros)
    load(8'b1011, 4'd4, 1'b1);
    stream(32'b101, 3);
    do_reset();
    bit_in(1'b1);
    stream(32'h0, 8);
    idle(1);

    // random phase
    for (int i = 0; i < 2000; i++) begin
      logic ld, clr;
      logic [LEN_W-1:0] l;
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      l   = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                        : LEN_W'($urandom_range(1, 4));
      if (i % 700 == 350) do_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom), ld, PAT_W'($urandom), l,
           1'($urandom), clr);
    end
    idle(1);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
